// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-port APB master controller.
package apb_arb_pkg;

   localparam int ADDR_W        = 9;
   localparam int DATA_W        = 8;
   localparam int SLAVE_SEL_BIT = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; ptr names the port favoured on the next tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   logic ptr;

   // After granting port k the other port is favoured; grant is one-hot so grant[0] is that index.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (update && (grant != 2'b00)) begin
         ptr <= grant[0];
      end
   end

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/apb_two_slave_arbiter.sv
// Shares one APB bus between two requester ports and two slaves, with a
// round-robin grant and a wait-state timeout so a silent slave cannot hang the bus.
//
//   state  | meaning
//   IDLE   | bus quiet; accept one pending request and latch it
//   SETUP  | PSELx high, PENABLE low, address/data/direction driven
//   ACCESS | PSELx and PENABLE high; wait for PREADY or timeout
module apb_two_slave_arbiter
   import apb_arb_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic              PCLK,
   input  logic              PRESET,

   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,

   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,

   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [7:0]        PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA1,
   input  logic [DATA_W-1:0] PRDATA2,
   input  logic              PREADY1,
   input  logic              PREADY2
);

   state_e              state, state_nxt;
   logic [1:0]          grant;
   logic                accept;
   logic                done_ok;
   logic                done_err;

   logic                lat_write;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic                lat_port;
   logic [CW-1:0]       wait_cnt;

   logic                sel_ready;
   logic [DATA_W-1:0]   sel_prdata;

   logic                psel1_c, psel2_c, penable_c, pwrite_c;
   logic [7:0]          paddr_c;
   logic [DATA_W-1:0]   pwdata_c;

   rr_arbiter2 u_rr (
      .clk    (PCLK),
      .rst    (PRESET),
      .req    ({req1_valid, req0_valid}),
      .update (accept),
      .grant  (grant)
   );

   assign sel_ready  = lat_addr[SLAVE_SEL_BIT] ? PREADY2 : PREADY1;
   assign sel_prdata = lat_addr[SLAVE_SEL_BIT] ? PRDATA2 : PRDATA1;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_ok   = 1'b0;
      done_err  = 1'b0;
      psel1_c   = 1'b0;
      psel2_c   = 1'b0;
      penable_c = 1'b0;
      pwrite_c  = 1'b0;
      paddr_c   = '0;
      pwdata_c  = '0;
      case (state)
         IDLE: begin
            if ((grant != 2'b00) && !PRESET) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            psel1_c   = ~lat_addr[SLAVE_SEL_BIT];
            psel2_c   =  lat_addr[SLAVE_SEL_BIT];
            pwrite_c  = lat_write;
            paddr_c   = lat_addr[7:0];
            pwdata_c  = lat_wdata;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel1_c   = ~lat_addr[SLAVE_SEL_BIT];
            psel2_c   =  lat_addr[SLAVE_SEL_BIT];
            penable_c = 1'b1;
            pwrite_c  = lat_write;
            paddr_c   = lat_addr[7:0];
            pwdata_c  = lat_wdata;
            // A ready slave wins over a timeout landing in the same cycle.
            if (sel_ready) begin
               done_ok   = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == CW'(TIMEOUT)) begin
               done_err  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_port   <= 1'b0;
         wait_cnt   <= '0;
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_rdata <= '0;
         rsp1_err   <= 1'b0;
         if (accept) begin
            lat_port  <= grant[1];
            lat_write <= grant[1] ? req1_write : req0_write;
            lat_addr  <= grant[1] ? req1_addr  : req0_addr;
            lat_wdata <= grant[1] ? req1_wdata : req0_wdata;
            wait_cnt  <= '0;
         end
         if (state == ACCESS) begin
            if (done_ok || done_err) begin
               wait_cnt <= '0;
            end else begin
               wait_cnt <= wait_cnt + CW'(1);
            end
         end
         if (done_ok || done_err) begin
            if (lat_port) begin
               rsp1_valid <= 1'b1;
               rsp1_err   <= done_err;
               rsp1_rdata <= (done_ok && !lat_write) ? sel_prdata : '0;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_err   <= done_err;
               rsp0_rdata <= (done_ok && !lat_write) ? sel_prdata : '0;
            end
         end
      end
   end

   assign req0_ready = accept & grant[0];
   assign req1_ready = accept & grant[1];

   assign PSEL1   = psel1_c;
   assign PSEL2   = psel2_c;
   assign PENABLE = penable_c;
   assign PWRITE  = pwrite_c;
   assign PADDR   = paddr_c;
   assign PWDATA  = pwdata_c;

endmodule

// File: tb/tb_apb_two_slave_arbiter.sv
// Directed bench for apb_two_slave_arbiter: slaves are modelled by driving PREADY/PRDATA by hand.
module tb_apb_two_slave_arbiter;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       req0_valid, req0_write, req1_valid, req1_write;
   logic [8:0] req0_addr, req1_addr;
   logic [7:0] req0_wdata, req1_wdata;
   logic       req0_ready, req1_ready;
   logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [7:0] rsp0_rdata, rsp1_rdata;
   logic       PSEL1, PSEL2, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
   logic       PREADY1, PREADY2;

   int errors = 0;
   int checks = 0;
   int cnt;

   apb_two_slave_arbiter #(.TIMEOUT(16), .CW(5)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
      .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
      .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
      .PREADY1(PREADY1), .PREADY2(PREADY2)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus_idle(input string tag);
      chk({tag, "_apb"}, {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 32'h0);
   endtask

   initial begin
      PRESET = 1'b1;
      req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
      PRDATA1 = '0; PRDATA2 = '0; PREADY1 = 0; PREADY2 = 0;
      tick(); tick();
      PRESET = 1'b0;
      chk_bus_idle("reset");
      chk("reset_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready}, 0);

      // Port 0 writes 0xA5 to 0x105, zero wait states on slave2
      req0_valid = 1; req0_write = 1; req0_addr = 9'h105; req0_wdata = 8'hA5; PREADY2 = 1;
      #1;
      chk("wr_ready", {req0_ready, req1_ready}, 2'b10);
      tick();
      req0_valid = 0;
      chk("wr_setup", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0101);
      chk("wr_setup_addr", {PADDR, PWDATA}, 16'h05A5);
      chk("wr_setup_ready", req0_ready, 0);
      tick();
      chk("wr_access", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0111);
      chk("wr_access_addr", {PADDR, PWDATA}, 16'h05A5);
      tick();
      chk("wr_rsp", {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid}, {1'b1, 1'b0, 8'h00, 1'b0});
      chk_bus_idle("wr_done");
      tick();
      chk("wr_rsp_pulse", rsp0_valid, 0);
      PREADY2 = 0;

      // Port 1 reads 0x003 from slave1 with three wait states
      req1_valid = 1; req1_write = 0; req1_addr = 9'h003; PRDATA1 = 8'h3C;
      #1;
      chk("rd_ready", {req0_ready, req1_ready}, 2'b01);
      tick();
      req1_valid = 0;
      chk("rd_setup", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR}, {4'b1000, 8'h03});
      tick();
      chk("rd_acc1", {PSEL1, PSEL2, PENABLE}, 3'b101);
      tick();
      chk("rd_acc2", {PSEL1, PSEL2, PENABLE}, 3'b101);
      tick();
      chk("rd_acc3", {PSEL1, PSEL2, PENABLE}, 3'b101);
      tick();
      PREADY1 = 1;
      chk("rd_acc4", {PSEL1, PSEL2, PENABLE}, 3'b101);
      tick();
      PREADY1 = 0;
      chk("rd_rsp", {rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid}, {1'b1, 1'b0, 8'h3C, 1'b0});
      chk_bus_idle("rd_done");

      // Both ports continuously valid after reset: grants alternate 0,1,0,1
      PRESET = 1; tick(); PRESET = 0;
      req0_valid = 1; req0_write = 0; req0_addr = 9'h010;
      req1_valid = 1; req1_write = 0; req1_addr = 9'h120;
      PRDATA1 = 8'h11; PRDATA2 = 8'h22; PREADY1 = 1; PREADY2 = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         chk($sformatf("rr_setup_ready%0d", i), {req0_ready, req1_ready}, 2'b00);
         tick();
         chk($sformatf("rr_access_ready%0d", i), {req0_ready, req1_ready}, 2'b00);
         tick();
         if (i % 2 == 0)
            chk($sformatf("rr_rsp%0d", i), {rsp0_valid, rsp1_valid, rsp0_rdata}, {2'b10, 8'h11});
         else
            chk($sformatf("rr_rsp%0d", i), {rsp0_valid, rsp1_valid, rsp1_rdata}, {2'b01, 8'h22});
      end
      req0_valid = 0; req1_valid = 0; PREADY1 = 0; PREADY2 = 0;
      tick();

      // Timeout: slave2 never ready
      req0_valid = 1; req0_write = 0; req0_addr = 9'h1FF; PRDATA2 = 8'h77;
      tick();
      req0_valid = 0;
      tick();
      cnt = 0;
      while (PENABLE && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("to_access_len", cnt, 17);
      chk("to_rsp", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b11, 8'h00});
      chk_bus_idle("to_done");

      // Reset in the second ACCESS cycle aborts with no response
      req0_valid = 1; req0_write = 1; req0_addr = 9'h004; req0_wdata = 8'h99;
      tick();
      req0_valid = 0;
      tick();
      tick();
      chk("rst_in_acc2", PENABLE, 1);
      PRESET = 1;
      tick();
      PRESET = 0;
      chk_bus_idle("rst_abort");
      chk("rst_abort_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
      req0_valid = 1; req1_valid = 1; req1_write = 0; req1_addr = 9'h001; PRDATA1 = 8'hC3;
      #1;
      chk("rst_ptr", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 0;
      #1;
      chk("rst_p1_ready", {req0_ready, req1_ready}, 2'b01);
      tick();
      req1_valid = 0; PREADY1 = 1;
      tick();
      tick();
      PREADY1 = 0;
      chk("rst_p1_rsp", {rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid}, {2'b10, 8'hC3, 1'b0});

      // PREADY1 on the exact timeout cycle wins
      req1_valid = 1; req1_write = 0; req1_addr = 9'h002; PRDATA1 = 8'h5A;
      tick();
      req1_valid = 0;
      tick();
      for (int i = 0; i < 16; i++) tick();
      PREADY1 = 1;
      chk("edge_acc17", PENABLE, 1);
      tick();
      PREADY1 = 0;
      chk("edge_rsp", {rsp1_valid, rsp1_err, rsp1_rdata}, {2'b10, 8'h5A});
      chk_bus_idle("edge_done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_two_slave_arbiter.md
Name: apb_two_slave_arbiter

Overview:
APB master-side controller that shares one APB bus between two independent requester ports (port 0, port 1) and the two 8-bit, 64-entry APB slaves.
- Arbitrates round-robin between the two ports.
- Decodes a 9-bit request address into PSEL1/PSEL2.
- Sequences the APB SETUP and ACCESS phases, muxes PREADY/PRDATA from the selected slave, and returns a per-port response.
- A wait-state timeout guarantees forward progress when a slave never asserts PREADY.

Parameters:
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (must be >=1)
CW, 5, width of wait counter (must satisfy 2^CW > TIMEOUT)

Ports:
PCLK  in  1  system clock; all logic on rising edge
PRESET  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request pending; held until req0_ready
req0_write  in  1  port 0: 1=write, 0=read
req0_addr  in  9  port 0: [8] slave select (0=slave1, 1=slave2), [7:0] slave address
req0_wdata  in  8  port 0 write data
req0_ready  out  1  port 0 request accepted (1-cycle pulse)
rsp0_valid  out  1  port 0 transfer complete (1-cycle pulse)
rsp0_rdata  out  8  port 0 read data, valid with rsp0_valid
rsp0_err  out  1  port 0 timeout flag, valid with rsp0_valid
req1_*, rsp1_*  as port 0, for port 1
PSEL1  out  1  APB select, slave1
PSEL2  out  1  APB select, slave2
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  8  APB address
PWDATA  out  8  APB write data
PRDATA1  in  8  slave1 read data
PRDATA2  in  8  slave2 read data
PREADY1  in  1  slave1 ready
PREADY2  in  1  slave2 ready

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - state=IDLE; all outputs 0; rr pointer=0 (port 0 favoured next); wait counter=0.
  - Overrides any in-flight transfer; no response is issued for an aborted transfer.
- FSM states:
  - IDLE: if any reqN_valid, grant one port, pulse reqN_ready, latch write/addr/wdata and the owning port; next=SETUP.
  - SETUP (1 cycle): PSELx=1 per latched addr[8], PENABLE=0, PWRITE/PADDR/PWDATA driven from the latch; next=ACCESS.
  - ACCESS: PSELx=1, PENABLE=1, outputs held stable; sel_ready = addr[8] ? PREADY2 : PREADY1.
    - sel_ready=1: complete OK; next=IDLE.
    - Otherwise, wait counter reaching TIMEOUT: complete with error; next=IDLE.
    - Otherwise: counter++, stay in ACCESS.
- Completion (registered, cycle after the exit edge):
  - rspN_valid=1 for the owning port only.
  - rspN_rdata = read ? selected PRDATA sampled with sel_ready : 0.
  - rspN_err=1 only on timeout; error response gives rdata=0.
- All APB outputs return to 0 in IDLE. Unselected PSEL is always 0; PSEL1 and PSEL2 are never both 1.
- Arbitration:
  - Only one valid request: grant it.
  - Both valid: grant the port != last-granted; rr pointer updates on every grant.
  - Requests arriving outside IDLE wait; no back-to-back pipelining. Minimum 3 cycles per transfer (IDLE, SETUP, ACCESS).
- Latency: accept at edge T; SETUP T+1; ACCESS T+2; with zero wait states rsp_valid is high in cycle T+3.
- Timeout: ACCESS lasts at most TIMEOUT+1 cycles. PREADY arriving in the same cycle as the timeout wins (OK, not error).
- Address: addr[7:0] is passed unchanged. Slaves decode only the entries they implement; the controller does no range check.
- reqN_ready is never asserted for a port whose reqN_valid is low.

Decomposition:
- Shared package apb_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - constants ADDR_W=9, DATA_W=8, SLAVE_SEL_BIT=8
- Natural sub-module rr_arbiter2: 2-input round-robin grant with pointer register and update-on-grant input.
- FSM, latch and APB mux stay in the top level.

Test Plan:
- Port 0 writes 0xA5 to addr 0x105, slave PREADY2=1 in first ACCESS cycle -> PSEL2=1 for 2 cycles, PENABLE high 1 cycle, PADDR=0x05, PWDATA=0xA5; rsp0_valid at T+3 with err=0.
- Port 1 reads addr 0x03, PREADY1 delayed 3 ACCESS cycles, PRDATA1=0x3C -> ACCESS lasts 4 cycles; rsp1_rdata=0x3C, err=0; PSEL2 stays 0.
- Both ports valid continuously for 4 transfers from reset -> grants alternate 0,1,0,1; each req_ready is a single-cycle pulse.
- TIMEOUT=16, PREADY2 held 0 -> ACCESS lasts 17 cycles; rsp_valid with err=1, rdata=0; then IDLE with all APB outputs 0.
- PRESET asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, no rsp_valid; a subsequent request from port 1 is granted (pointer reset).
- PREADY1 rises on the exact timeout cycle -> completes with err=0 and the sampled PRDATA1.
